// File: rtl/add_serial_param_pkg.sv
// Shared types and constants for the digit-serial adder/subtractor.
package add_serial_pkg;

  // Controller states. CHK is only reachable when ADD_SERIAL_KEY_EN is defined.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CHK  = 2'd1,
    ADD  = 2'd2,
    DONE = 2'd3
  } state_e;

  // Key that the decoy prologue expects when the instance does not override it.
  localparam logic [3:0] KEY_DEFAULT = 4'b1011;

  // Only digit widths of 1, 2 and 4 bits are supported.
  function automatic bit d_is_legal(input int d);
    return (d == 1) || (d == 2) || (d == 4);
  endfunction

endpackage

// File: rtl/add_serial_param_if.sv
// Start/result handshake bundle for add_serial_param.
interface add_serial_param_if #(
  parameter int W       = 8,
  parameter int KEY_LEN = 4
);
  logic               start_valid;
  logic               start_ready;
  logic [W-1:0]       a;
  logic [W-1:0]       b;
  logic               sub;
  logic [KEY_LEN-1:0] key;
  logic               res_valid;
  logic               res_ready;
  logic [W-1:0]       res;
  logic               cout;
  logic               ovf;
  logic               err;

  modport master (
    output start_valid, a, b, sub, key, res_ready,
    input  start_ready, res_valid, res, cout, ovf, err
  );

  modport slave (
    input  start_valid, a, b, sub, key, res_ready,
    output start_ready, res_valid, res, cout, ovf, err
  );
endinterface

// File: rtl/add_serial_param_digit.sv
// Combinational D-bit digit adder. Besides the carry-out it exports the carry
// flowing into its top bit, which the controller needs for signed overflow.
module add_serial_digit #(
  parameter int D = 1
) (
  input  logic [D-1:0] a_i,
  input  logic [D-1:0] b_i,
  input  logic         cin_i,
  output logic [D-1:0] sum_o,
  output logic         cout_o,
  output logic         cmsb_o
);

  logic [D:0] full;

  // D+1-bit sum keeps the carry-out as the top bit
  always_comb begin
    full = {1'b0, a_i} + {1'b0, b_i} + {{D{1'b0}}, cin_i};
  end

  assign sum_o  = full[D-1:0];
  assign cout_o = full[D];
  // Carry into bit D-1 recovered from that bit's sum and operand bits.
  assign cmsb_o = full[D-1] ^ a_i[D-1] ^ b_i[D-1];

endmodule

// File: rtl/add_serial_param.sv
// Digit-serial adder/subtractor, D bits per cycle, LSB first.
// Optional feature macro: ADD_SERIAL_KEY_EN adds a key-checked CHK prologue
// between operand capture and the arithmetic; without it key is ignored and
// err is constant 0.
module add_serial_param
  import add_serial_pkg::*;
#(
  parameter int                 W       = 8,
  parameter int                 D       = 1,
  parameter int                 KEY_LEN = 4,
  parameter logic [KEY_LEN-1:0] KEY     = KEY_LEN'(KEY_DEFAULT)
) (
  input logic               clk,
  input logic               rst_n,
  add_serial_param_if.slave bus
);

  localparam int            NDIG = W / D;
  localparam int            CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

  if (!d_is_legal(D) || (W % D) != 0 || KEY_LEN < 1) begin : g_bad_param
    $error("add_serial_param: illegal W/D/KEY_LEN combination");
  end

  state_e        state_q;
  logic [W-1:0]  a_q, b_q, res_q, res_d;
  logic          carry_q;
  logic [CW-1:0] cnt_q;
  logic          cout_q, ovf_q, err_q, res_valid_q, start_ready_q;

  logic [D-1:0]  dsum;
  logic          dcout, dcmsb;

`ifdef ADD_SERIAL_KEY_EN
  localparam int            KW   = (KEY_LEN > 1) ? $clog2(KEY_LEN) : 1;
  localparam logic [KW-1:0] KLST = KW'(KEY_LEN - 1);
  logic [KW-1:0] kidx_q;
`else
  logic unused_cfg;
  assign unused_cfg = ^{bus.key, KEY};
`endif

  add_serial_digit #(.D(D)) u_digit (
    .a_i    (a_q[D-1:0]),
    .b_i    (b_q[D-1:0]),
    .cin_i  (carry_q),
    .sum_o  (dsum),
    .cout_o (dcout),
    .cmsb_o (dcmsb)
  );

  // New digit enters res from the MSB side so the first digit ends up at the LSB.
  if (W == D) begin : g_res_one
    assign res_d = dsum;
  end else begin : g_res_shift
    assign res_d = {dsum, res_q[W-1:D]};
  end

  // Sequencer: operand capture, optional key prologue, serial add, result hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      a_q           <= '0;
      b_q           <= '0;
      carry_q       <= 1'b0;
      cnt_q         <= '0;
      res_q         <= '0;
      cout_q        <= 1'b0;
      ovf_q         <= 1'b0;
      err_q         <= 1'b0;
      res_valid_q   <= 1'b0;
      start_ready_q <= 1'b0;
`ifdef ADD_SERIAL_KEY_EN
      kidx_q        <= '0;
`endif
    end else begin
      err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          start_ready_q <= 1'b1;
          if (bus.start_valid && start_ready_q) begin
            // Subtraction is A + ~B + 1: invert B and seed the carry.
            a_q           <= bus.a;
            b_q           <= bus.sub ? ~bus.b : bus.b;
            carry_q       <= bus.sub;
            cnt_q         <= '0;
            res_q         <= '0;
            cout_q        <= 1'b0;
            ovf_q         <= 1'b0;
            start_ready_q <= 1'b0;
`ifdef ADD_SERIAL_KEY_EN
            kidx_q        <= '0;
            state_q       <= CHK;
`else
            state_q       <= ADD;
`endif
          end
        end
`ifdef ADD_SERIAL_KEY_EN
        CHK: begin
          if (bus.key[kidx_q] != KEY[kidx_q]) begin
            a_q           <= '0;
            b_q           <= '0;
            carry_q       <= 1'b0;
            err_q         <= 1'b1;
            start_ready_q <= 1'b1;
            state_q       <= IDLE;
          end else if (kidx_q == KLST) begin
            cnt_q   <= '0;
            state_q <= ADD;
          end else begin
            kidx_q <= kidx_q + KW'(1);
          end
        end
`endif
        ADD: begin
          res_q   <= res_d;
          a_q     <= a_q >> D;
          b_q     <= b_q >> D;
          carry_q <= dcout;
          cnt_q   <= cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            cout_q      <= dcout;
            ovf_q       <= dcmsb ^ dcout;
            res_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (bus.res_ready) begin
            res_valid_q   <= 1'b0;
            start_ready_q <= 1'b1;
            state_q       <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.start_ready = start_ready_q;
  assign bus.res_valid   = res_valid_q;
  assign bus.res         = res_q;
  assign bus.cout        = cout_q;
  assign bus.ovf         = ovf_q;
  assign bus.err         = err_q;

endmodule
